// File: rtl/dual_port_ram_resp.sv
// Responder side of the dual-port RAM: 1-cycle registered read, write-first forwarding on
// address collision, written-location tracking and saturating per-port transaction counters.
module dual_port_ram_resp #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_valid,
    output logic                  uninit_read,
    output logic                  collision,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      written_q;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  read_valid_q, read_valid_d;
    logic                  uninit_q, uninit_d;
    logic                  collision_q, collision_d;
    logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic                  addr_match;

    assign addr_match = write_enable && (write_address == read_address);

    // Array is deliberately unreset; the written bitmap hides stale contents instead.
    always_ff @(posedge clk) begin
        if (write_enable && rst_n) begin
            mem[write_address] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else if (write_enable) begin
            written_q[write_address] <= 1'b1;
        end
    end

    always_comb begin
        data_out_d   = data_out_q;
        read_valid_d = 1'b0;
        uninit_d     = 1'b0;
        collision_d  = 1'b0;
        if (read_enable) begin
            read_valid_d = 1'b1;
            if (addr_match) begin
                data_out_d  = data_in;
                collision_d = 1'b1;
            end else if (written_q[read_address]) begin
                data_out_d = mem[read_address];
            end else begin
                data_out_d = '0;
                uninit_d   = 1'b1;
            end
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (write_enable && (wr_count_q != CntMax)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
        if (read_enable && (rd_count_q != CntMax)) begin
            rd_count_d = rd_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
            uninit_q     <= 1'b0;
            collision_q  <= 1'b0;
            wr_count_q   <= '0;
            rd_count_q   <= '0;
        end else begin
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
            uninit_q     <= uninit_d;
            collision_q  <= collision_d;
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
        end
    end

    assign data_out    = data_out_q;
    assign read_valid  = read_valid_q;
    assign uninit_read = uninit_q;
    assign collision   = collision_q;
    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_dual_port_ram_resp.sv
// Randomised bench for dual_port_ram_resp against an array-based reference model; a second
// instance with 4-bit counters exercises saturation on the same stimulus.
module tb_dual_port_ram_resp;

    localparam int unsigned Depth = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] data_in = '0;
    logic [11:0] write_address = '0;
    logic [11:0] read_address = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;

    logic [63:0] data_out, data_out4;
    logic        read_valid, uninit_read, collision;
    logic        read_valid4, uninit_read4, collision4;
    logic [15:0] wr_count, rd_count;
    logic [3:0]  wr_count4, rd_count4;

    always #5 clk = ~clk;

    dual_port_ram_resp u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .write_address (write_address),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .read_enable   (read_enable),
        .data_out      (data_out),
        .read_valid    (read_valid),
        .uninit_read   (uninit_read),
        .collision     (collision),
        .wr_count      (wr_count),
        .rd_count      (rd_count)
    );

    dual_port_ram_resp #(.CNT_WIDTH(4)) u_dut_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .write_address (write_address),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .read_enable   (read_enable),
        .data_out      (data_out4),
        .read_valid    (read_valid4),
        .uninit_read   (uninit_read4),
        .collision     (collision4),
        .wr_count      (wr_count4),
        .rd_count      (rd_count4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain memory, written flags, counts of accepted transactions.
    logic [63:0] mem_m [Depth];
    bit          written_m [Depth];
    logic [63:0] exp_data;
    bit          exp_valid, exp_uninit, exp_coll;
    int          wr_n, rd_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic check_outputs();
        check("data_out", data_out, exp_data);
        check("read_valid", 64'(read_valid), 64'(exp_valid));
        check("uninit_read", 64'(uninit_read), 64'(exp_uninit));
        check("collision", 64'(collision), 64'(exp_coll));
        check("wr_count", 64'(wr_count), 64'(sat(wr_n, 65535)));
        check("rd_count", 64'(rd_count), 64'(sat(rd_n, 65535)));
        check("wr_count4", 64'(wr_count4), 64'(sat(wr_n, 15)));
        check("rd_count4", 64'(rd_count4), 64'(sat(rd_n, 15)));
        check("data_out4", data_out4, exp_data);
    endtask

    task automatic model_reset();
        for (int i = 0; i < Depth; i++) written_m[i] = 1'b0;
        exp_data = '0;
        exp_valid = 0;
        exp_uninit = 0;
        exp_coll = 0;
        wr_n = 0;
        rd_n = 0;
    endtask

    // Applies the current inputs as one clock edge of the reference model.
    task automatic model_edge();
        exp_valid = 0;
        exp_uninit = 0;
        exp_coll = 0;
        if (read_enable) begin
            rd_n++;
            exp_valid = 1;
            if (write_enable && write_address == read_address) begin
                exp_data = data_in;
                exp_coll = 1;
            end else if (written_m[read_address]) begin
                exp_data = mem_m[read_address];
            end else begin
                exp_data = '0;
                exp_uninit = 1;
            end
        end
        if (write_enable) begin
            wr_n++;
            mem_m[write_address] = data_in;
            written_m[write_address] = 1'b1;
        end
    endtask

    // Entered 1 unit after a posedge: drive, check previous result at negedge, clock the model.
    task automatic step(input bit w, input logic [11:0] wa, input logic [63:0] d,
                        input bit r, input logic [11:0] ra);
        write_enable = w;
        write_address = wa;
        data_in = d;
        read_enable = r;
        read_address = ra;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_open();
        write_enable = 1'b0;
        read_enable = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_close();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        check("rst_read_valid", 64'(read_valid), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_rd_count", 64'(rd_count), 64'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom % 4)
            0, 1:    return 12'($urandom_range(0, 15));
            2:       return 12'hFFF - 12'($urandom_range(0, 3));
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        // Reset held 3 cycles with both strobes active: nothing may be accepted.
        #1 rst_n = 1'b0;
        write_enable = 1'b1;
        read_enable = 1'b1;
        write_address = 12'h000;
        read_address = 12'h000;
        data_in = 64'h1111_2222_3333_4444;
        repeat (3) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        step(0, 12'h000, '0, 1, 12'h000);
        idle_open();
        check("post_rst_uninit", 64'(uninit_read), 64'd1);
        check("post_rst_data", data_out, 64'd0);
        idle_close();

        // Write then read.
        step(1, 12'hABC, 64'h0123_4567_89AB_CDEF, 0, 12'h000);
        step(0, 12'h000, '0, 1, 12'hABC);
        idle_open();
        check("wr_rd_data", data_out, 64'h0123_4567_89AB_CDEF);
        check("wr_rd_valid", 64'(read_valid), 64'd1);
        idle_close();

        // Same-edge collision on a previously written location.
        step(1, 12'h010, 64'h5, 0, 12'h000);
        step(1, 12'h010, 64'hDEAD_BEEF_0000_0001, 1, 12'h010);
        idle_open();
        check("coll_data", data_out, 64'hDEAD_BEEF_0000_0001);
        check("coll_flag", 64'(collision), 64'd1);
        idle_close();

        // Boundary addresses read back-to-back.
        pulse_reset();
        step(1, 12'h000, 64'hA5A5_0000_0000_0001, 0, 12'h000);
        step(1, 12'hFFF, 64'h5A5A_FFFF_FFFF_FFFE, 0, 12'h000);
        step(0, 12'h000, '0, 1, 12'h000);
        step(0, 12'h000, '0, 1, 12'hFFF);
        idle_open();
        check("bnd_data_fff", data_out, 64'h5A5A_FFFF_FFFF_FFFE);
        check("bnd_wr_count", 64'(wr_count), 64'd2);
        check("bnd_rd_count", 64'(rd_count), 64'd2);
        idle_close();

        // Saturation of the narrow counters, then reset in the middle of a read.
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 12'(i), {$urandom, $urandom}, 0, 12'h000);
        end
        idle_open();
        check("sat_wr_count4", 64'(wr_count4), 64'd15);
        check("sat_wr_count", 64'(wr_count), 64'd20);
        idle_close();
        step(0, 12'h000, '0, 1, 12'h003);
        pulse_reset();
        idle_open();
        check("midrst_valid", 64'(read_valid), 64'd0);
        idle_close();
        step(0, 12'h000, '0, 1, 12'h003);
        idle_open();
        check("midrst_uninit", 64'(uninit_read), 64'd1);
        idle_close();

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [11:0] wa, ra;
            wa = pick_addr();
            ra = ($urandom % 8 == 0) ? wa : pick_addr();
            step(($urandom % 10) < 6, wa, {$urandom, $urandom}, ($urandom % 10) < 6, ra);
        end
        idle_open();
        idle_close();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
